seq_ctrl: RTL and testbench

Multi-cycle sequencer for the 9-bit core datapath: PC, instr_ROM, Control, reg_file, alu, dat_mem. It steps each instruction through FETCH, DECODE, EXEC, an optional MEM and WB. It gates the PC, instruction latch, register-file write, flag registers and data-memory request, and reports run status and performance counters to top_level.

---
 rtl/seq_pkg.sv | 28 ++
 rtl/sat_cnt.sv | 28 ++
 rtl/seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_seq_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared state/class encodings for the multi-cycle sequencer.
// Contents:
//   state_t     - sequencer states IDLE..DONE
//   icls_t      - legal instruction classes reported by Control
//   ILLEGAL_MIN - first class code that is treated as illegal
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        C_ALU,
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_HALT
    } icls_t;

    localparam logic [2:0] ILLEGAL_MIN = 3'd5;

endpackage

// File: rtl/sat_cnt.sv
// sat_cnt: up-counter with enable and synchronous clear that holds at all-ones.
// Ports:
//   clk_i   - clock
//   reset_i - asynchronous active-high reset (counter to 0)
//   en_i    - count enable
//   clr_i   - synchronous clear, dominates en_i
//   cnt_o   - current count
module sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_ctrl.sv
// seq_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 9-bit core.
// Ports:
//   clk_i, reset_i            - clock, asynchronous active-high reset
//   start_i                   - launch pulse, honoured in IDLE or DONE only
//   instr_cls_i               - class from Control, sampled in DECODE
//   branch_taken_i            - branch condition, used in WB
//   mem_ack_i                 - data-memory completion, sampled in MEM only
//   pc_clr_o, pc_en_o, pc_jump_o, ir_ld_o, flag_en_o, rf_we_o,
//   mem_req_o, mem_we_o       - datapath strobes, decoded from registered state
//   busy_o, done_o, err_o     - run status (err sticky until next launch)
//   cyc_cnt_o, instr_cnt_o    - saturating busy-cycle and retired-instruction counts
module seq_ctrl
    import seq_pkg::*;
#(
    parameter int CW  = 16,
    parameter int TMO = 8
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_i,
    input  logic [2:0]    instr_cls_i,
    input  logic          branch_taken_i,
    input  logic          mem_ack_i,
    output logic          pc_clr_o,
    output logic          pc_en_o,
    output logic          pc_jump_o,
    output logic          ir_ld_o,
    output logic          flag_en_o,
    output logic          rf_we_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [CW-1:0] cyc_cnt_o,
    output logic [CW-1:0] instr_cnt_o
);

    localparam int WW = $clog2(TMO + 1);

    state_t        state_q, state_d;
    icls_t         cls_q, cls_d;
    logic          err_q, err_d;
    logic          clr_q;
    logic          launch, tmo_hit, in_mem, in_wb;
    logic [WW-1:0] wait_cnt;

    // The wait counter holds the number of MEM cycles already completed, so
    // the last allowed MEM cycle is the one where it reads TMO-1.
    assign tmo_hit = wait_cnt == WW'(TMO - 1);
    assign in_mem  = state_q == S_MEM;
    assign in_wb   = state_q == S_WB;

    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            state_q <= S_IDLE;
            cls_q   <= C_ALU;
            err_q   <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            err_q   <= err_d;
            clr_q   <= launch;
        end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        err_d   = err_q;
        launch  = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE:
                if (start_i) begin
                    state_d = S_FETCH;
                    launch  = 1'b1;
                    err_d   = 1'b0;
                end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE:
                if (instr_cls_i >= ILLEGAL_MIN) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else if (instr_cls_i == C_HALT) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_EXEC;
                    cls_d   = icls_t'(instr_cls_i);
                end
            S_EXEC:   state_d = (cls_q == C_LOAD || cls_q == C_STORE) ? S_MEM : S_WB;
            // An ack on the final allowed cycle still completes the access.
            S_MEM:
                if (mem_ack_i) begin
                    state_d = S_WB;
                end else if (tmo_hit) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        // clr_q is set only by the launch edge, so it is high for exactly the first FETCH.
        pc_clr_o  = clr_q;
        pc_en_o   = in_wb;
        pc_jump_o = in_wb && cls_q == C_BRANCH && branch_taken_i;
        ir_ld_o   = state_q == S_FETCH;
        flag_en_o = state_q == S_EXEC && cls_q == C_ALU;
        rf_we_o   = in_wb && (cls_q == C_ALU || cls_q == C_LOAD);
        mem_req_o = in_mem;
        mem_we_o  = in_mem && cls_q == C_STORE;
        busy_o    = state_q != S_IDLE && state_q != S_DONE;
        done_o    = state_q == S_DONE;
        err_o     = err_q;
    end

    sat_cnt #(.W(CW)) u_cyc (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (busy_o),
        .clr_i   (launch),
        .cnt_o   (cyc_cnt_o)
    );

    sat_cnt #(.W(CW)) u_instr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (in_wb),
        .clr_i   (launch),
        .cnt_o   (instr_cnt_o)
    );

    // Held at zero outside MEM, so every MEM visit starts counting from 0.
    sat_cnt #(.W(WW)) u_wait (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (in_mem),
        .clr_i   (!in_mem),
        .cnt_o   (wait_cnt)
    );

endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: directed self-checking bench for seq_ctrl (default CW and a CW=4 copy in lockstep).
module tb_seq_ctrl;
    import seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  instr_cls = 3'd7;
    logic        branch_taken = 1'b0;
    logic        mem_ack = 1'b0;

    logic        pc_clr_o, pc_en_o, pc_jump_o, ir_ld_o, flag_en_o, rf_we_o;
    logic        mem_req_o, mem_we_o, busy_o, done_o, err_o;
    logic [15:0] cyc_cnt_o, instr_cnt_o;

    logic        d4_pc_clr, d4_pc_en, d4_pc_jump, d4_ir_ld, d4_flag_en, d4_rf_we;
    logic        d4_mem_req, d4_mem_we, d4_busy, d4_done, d4_err;
    logic [3:0]  d4_cyc, d4_instr;

    logic [10:0] outs, outs4;
    assign outs  = {pc_clr_o, pc_en_o, pc_jump_o, ir_ld_o, flag_en_o, rf_we_o, mem_req_o, mem_we_o, busy_o, done_o, err_o};
    assign outs4 = {d4_pc_clr, d4_pc_en, d4_pc_jump, d4_ir_ld, d4_flag_en, d4_rf_we, d4_mem_req, d4_mem_we, d4_busy, d4_done, d4_err};

    int total = 0;
    int bad = 0;

    logic [2:0] prog [32];
    logic       bt [32];
    int         plen, ack_at;
    logic       stray, hold_start;
    int         n_clr, n_wb, n_rfwe, n_mem, n_memwe, n_flag, cycles;
    logic [7:0] jlog;
    logic       first_err;

    always #5 clk = ~clk;

    seq_ctrl dut (
        .clk_i(clk), .reset_i(rst), .start_i(start), .instr_cls_i(instr_cls),
        .branch_taken_i(branch_taken), .mem_ack_i(mem_ack),
        .pc_clr_o(pc_clr_o), .pc_en_o(pc_en_o), .pc_jump_o(pc_jump_o), .ir_ld_o(ir_ld_o),
        .flag_en_o(flag_en_o), .rf_we_o(rf_we_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .cyc_cnt_o(cyc_cnt_o), .instr_cnt_o(instr_cnt_o)
    );

    seq_ctrl #(.CW(4), .TMO(8)) dut4 (
        .clk_i(clk), .reset_i(rst), .start_i(start), .instr_cls_i(instr_cls),
        .branch_taken_i(branch_taken), .mem_ack_i(mem_ack),
        .pc_clr_o(d4_pc_clr), .pc_en_o(d4_pc_en), .pc_jump_o(d4_pc_jump), .ir_ld_o(d4_ir_ld),
        .flag_en_o(d4_flag_en), .rf_we_o(d4_rf_we), .mem_req_o(d4_mem_req), .mem_we_o(d4_mem_we),
        .busy_o(d4_busy), .done_o(d4_done), .err_o(d4_err),
        .cyc_cnt_o(d4_cyc), .instr_cnt_o(d4_instr)
    );

    // Launches the program in prog[0:plen-1] and records every strobe until DONE.
    // The class input is scrambled in EXEC to show it is latched in DECODE.
    task automatic run_prog;
        int idx, mcyc, sf;
        idx = 0; mcyc = 0; sf = 0;
        n_clr = 0; n_wb = 0; n_rfwe = 0; n_mem = 0; n_memwe = 0; n_flag = 0; cycles = 0; jlog = '0;
        mem_ack = 1'b0; branch_taken = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = hold_start;
        first_err = err_o;
        while (!done_o && cycles < 200) begin
            cycles++;
            if (pc_clr_o) n_clr++;
            if (flag_en_o) n_flag++;
            if (ir_ld_o) begin
                instr_cls = idx < plen ? prog[idx] : 3'(C_HALT);
                branch_taken = bt[idx];
                idx++;
                sf = 0;
            end else begin
                sf++;
            end
            if (sf == 2) instr_cls = 3'd7;
            if (mem_req_o) begin
                mcyc++;
                n_mem++;
                if (mem_we_o) n_memwe++;
                mem_ack = mcyc == ack_at;
            end else begin
                mcyc = 0;
                mem_ack = stray;
            end
            if (pc_en_o) begin
                n_wb++;
                jlog = {jlog[6:0], pc_jump_o};
            end
            if (rf_we_o) n_rfwe++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        mem_ack = 1'b0;
        total++; if (done_o !== 1'b1) begin bad++; $display("FAIL run.done_reached got=%b exp=1 after %0d cycles", done_o, cycles); end
    endtask

    task automatic setup(input int len, input int ack, input logic s, input logic h);
        plen = len; ack_at = ack; stray = s; hold_start = h;
        for (int i = 0; i < 32; i++) begin
            prog[i] = 3'(C_HALT);
            bt[i] = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (outs !== '0 || cyc_cnt_o !== '0 || instr_cnt_o !== '0) begin bad++; $display("FAIL reset.outs got=%b cyc=%0d ins=%0d exp=0", outs, cyc_cnt_o, instr_cnt_o); end
        total++; if (outs4 !== '0 || d4_cyc !== '0 || d4_instr !== '0) begin bad++; $display("FAIL reset.outs4 got=%b exp=0", outs4); end
        rst = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        total++; if (ir_ld_o !== 1'b1 || busy_o !== 1'b1 || pc_clr_o !== 1'b1) begin bad++; $display("FAIL reset.fetch got ir_ld=%b busy=%b pc_clr=%b exp=1,1,1", ir_ld_o, busy_o, pc_clr_o); end
        #2 rst = 1'b1;
        #1;
        total++; if (outs !== '0 || cyc_cnt_o !== '0 || instr_cnt_o !== '0) begin bad++; $display("FAIL reset.mid_fetch got=%b cyc=%0d exp=0", outs, cyc_cnt_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if (pc_en_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL reset.idle_hold got pc_en=%b busy=%b exp=0,0", pc_en_o, busy_o); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu_halt;
        setup(3, 0, 1'b0, 1'b0);
        prog[0] = 3'(C_ALU); prog[1] = 3'(C_ALU);
        run_prog();
        total++; if (n_clr !== 1) begin bad++; $display("FAIL alu.pc_clr got=%0d exp=1", n_clr); end
        total++; if (n_wb !== 2 || n_rfwe !== 2) begin bad++; $display("FAIL alu.wb got wb=%0d rf_we=%0d exp=2,2", n_wb, n_rfwe); end
        total++; if (n_flag !== 2) begin bad++; $display("FAIL alu.flag_en got=%0d exp=2", n_flag); end
        total++; if (instr_cnt_o !== 16'd2 || cyc_cnt_o !== 16'd10) begin bad++; $display("FAIL alu.counts got ins=%0d cyc=%0d exp=2,10", instr_cnt_o, cyc_cnt_o); end
        total++; if (done_o !== 1'b1 || err_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL alu.status got done=%b err=%b busy=%b exp=1,0,0", done_o, err_o, busy_o); end
    endtask

    task automatic test_load;
        setup(2, 3, 1'b1, 1'b0);
        prog[0] = 3'(C_LOAD);
        run_prog();
        total++; if (n_mem !== 3 || n_memwe !== 0) begin bad++; $display("FAIL load.mem got req=%0d we=%0d exp=3,0", n_mem, n_memwe); end
        total++; if (n_rfwe !== 1 || n_flag !== 0) begin bad++; $display("FAIL load.rf_we got rf_we=%0d flag=%0d exp=1,0", n_rfwe, n_flag); end
        total++; if (cycles !== 9 || cyc_cnt_o !== 16'd9 || instr_cnt_o !== 16'd1) begin bad++; $display("FAIL load.cycles got=%0d cyc=%0d ins=%0d exp=9,9,1", cycles, cyc_cnt_o, instr_cnt_o); end
    endtask

    task automatic test_store_timeout;
        setup(1, 0, 1'b0, 1'b0);
        prog[0] = 3'(C_STORE);
        run_prog();
        total++; if (n_mem !== 8 || n_memwe !== 8) begin bad++; $display("FAIL store_tmo.mem got req=%0d we=%0d exp=8,8", n_mem, n_memwe); end
        total++; if (err_o !== 1'b1 || done_o !== 1'b1 || n_wb !== 0) begin bad++; $display("FAIL store_tmo.err got err=%b done=%b wb=%0d exp=1,1,0", err_o, done_o, n_wb); end
        total++; if (instr_cnt_o !== 16'd0 || cyc_cnt_o !== 16'd11) begin bad++; $display("FAIL store_tmo.counts got ins=%0d cyc=%0d exp=0,11", instr_cnt_o, cyc_cnt_o); end
        setup(2, 8, 1'b0, 1'b0);
        prog[0] = 3'(C_STORE);
        run_prog();
        total++; if (n_mem !== 8 || err_o !== 1'b0 || n_wb !== 1) begin bad++; $display("FAIL store_lastack got req=%0d err=%b wb=%0d exp=8,0,1", n_mem, err_o, n_wb); end
        total++; if (cycles !== 14 || instr_cnt_o !== 16'd1 || n_rfwe !== 0) begin bad++; $display("FAIL store_lastack.counts got cyc=%0d ins=%0d rf_we=%0d exp=14,1,0", cycles, instr_cnt_o, n_rfwe); end
    endtask

    task automatic test_branch;
        setup(3, 0, 1'b0, 1'b0);
        prog[0] = 3'(C_BRANCH); bt[0] = 1'b1;
        prog[1] = 3'(C_BRANCH); bt[1] = 1'b0;
        run_prog();
        total++; if (n_wb !== 2 || jlog[1:0] !== 2'b10) begin bad++; $display("FAIL branch.jump got wb=%0d seq=%b exp=2,10", n_wb, jlog[1:0]); end
        total++; if (n_rfwe !== 0 || n_flag !== 0 || cycles !== 10) begin bad++; $display("FAIL branch.strobes got rf_we=%0d flag=%0d cyc=%0d exp=0,0,10", n_rfwe, n_flag, cycles); end
    endtask

    task automatic test_illegal_restart;
        setup(1, 0, 1'b0, 1'b0);
        prog[0] = 3'd6;
        run_prog();
        total++; if (cycles !== 2 || err_o !== 1'b1 || done_o !== 1'b1) begin bad++; $display("FAIL illegal got cyc=%0d err=%b done=%b exp=2,1,1", cycles, err_o, done_o); end
        total++; if (instr_cnt_o !== 16'd0) begin bad++; $display("FAIL illegal.instr_cnt got=%0d exp=0", instr_cnt_o); end
        setup(2, 0, 1'b0, 1'b1);
        prog[0] = 3'(C_ALU);
        run_prog();
        total++; if (first_err !== 1'b0) begin bad++; $display("FAIL restart.err_clear got=%b exp=0", first_err); end
        total++; if (n_clr !== 1 || cycles !== 6 || cyc_cnt_o !== 16'd6) begin bad++; $display("FAIL restart.busy_start got clr=%0d cyc=%0d cnt=%0d exp=1,6,6", n_clr, cycles, cyc_cnt_o); end
        total++; if (err_o !== 1'b0 || instr_cnt_o !== 16'd1) begin bad++; $display("FAIL restart.final got err=%b ins=%0d exp=0,1", err_o, instr_cnt_o); end
    endtask

    task automatic test_saturate;
        setup(21, 0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) prog[i] = 3'(C_ALU);
        run_prog();
        total++; if (instr_cnt_o !== 16'd20 || cyc_cnt_o !== 16'd82) begin bad++; $display("FAIL sat.wide got ins=%0d cyc=%0d exp=20,82", instr_cnt_o, cyc_cnt_o); end
        total++; if (d4_instr !== 4'd15 || d4_cyc !== 4'd15) begin bad++; $display("FAIL sat.cw4 got ins=%0d cyc=%0d exp=15,15", d4_instr, d4_cyc); end
        total++; if (outs4 !== outs) begin bad++; $display("FAIL sat.cw4_ctrl got=%b exp=%b", outs4, outs); end
    endtask

    initial begin
        test_reset();
        test_alu_halt();
        test_load();
        test_store_timeout();
        test_branch();
        test_illegal_restart();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
